// File: rtl/vetor_excecao.sv
// vetor_excecao: exception-vector unit.
// Latches rising edges of the per-channel exception requests into a sticky
// pending register. The lowest-numbered pending channel wins arbitration.
// The unit presents vector BASE+channel (wrapping in LARGURA bits) together
// with the channel index, and holds both until the control unit answers
// with aceita.
// Optional feature macro: VETOR_EXC_MASCARA_EN adds a per-channel mask input.
// A masked channel can neither set its pending bit nor raise sobreposicao.
module vetor_excecao #(
   parameter int LARGURA  = 8,
   parameter int N_CANAIS = 3,
   parameter int BASE     = 253
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_CANAIS-1:0] pedido,
`ifdef VETOR_EXC_MASCARA_EN
   input  logic [N_CANAIS-1:0] mascara,
`endif
   input  logic                aceita,
   output logic [LARGURA-1:0]  saida,
   output logic [3:0]          causa,
   output logic                pendente,
   output logic                sobreposicao
);

   localparam logic [0:0] OCIOSO = 1'b0;
   localparam logic [0:0] ATIVO  = 1'b1;

   localparam logic [LARGURA-1:0] BASE_L = LARGURA'(BASE);

   logic [N_CANAIS-1:0] pedido_ant_q;
   logic [N_CANAIS-1:0] pend_q, pend_d;
   logic [0:0]          estado_q, estado_d;
   logic [LARGURA-1:0]  saida_q, saida_d;
   logic [3:0]          causa_q, causa_d;
   logic                sobrep_q, sobrep_d;

   logic [N_CANAIS-1:0] borda_s;
   logic [N_CANAIS-1:0] habilita_s;
   logic [N_CANAIS-1:0] limpa_s;
   logic [3:0]          idx_s;

`ifdef VETOR_EXC_MASCARA_EN
   assign habilita_s = ~mascara;
`else
   assign habilita_s = {N_CANAIS{1'b1}};
`endif

   // Rising-edge detect on the requests, gated by the channel enables.
   always_comb begin
      borda_s = pedido & ~pedido_ant_q & habilita_s;
   end

   // Clear strobe: the serviced channel is released when aceita arrives in ATIVO.
   always_comb begin
      limpa_s = {N_CANAIS{1'b0}};
      for (int i = 0; i < N_CANAIS; i++) begin
         if ((estado_q == ATIVO) && aceita && (causa_q == 4'(i))) begin
            limpa_s[i] = 1'b1;
         end else begin
            limpa_s[i] = 1'b0;
         end
      end
   end

   // Fixed-priority encoder: the lowest set pending bit wins.
   always_comb begin
      idx_s = 4'd0;
      for (int i = N_CANAIS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            idx_s = 4'(i);
         end else begin
            idx_s = idx_s;
         end
      end
   end

   // Pending and overlap next-state. A new edge beats a same-cycle clear.
   always_comb begin
      pend_d   = (pend_q & ~limpa_s) | borda_s;
      sobrep_d = sobrep_q | (|(borda_s & pend_q & ~limpa_s));
   end

   // Service FSM: capture a vector in OCIOSO, hold it in ATIVO until accepted.
   always_comb begin
      estado_d = estado_q;
      saida_d  = saida_q;
      causa_d  = causa_q;
      case (estado_q)
         OCIOSO: begin
            if (pend_q != {N_CANAIS{1'b0}}) begin
               estado_d = ATIVO;
               causa_d  = idx_s;
               saida_d  = BASE_L + LARGURA'(idx_s);
            end else begin
               estado_d = OCIOSO;
            end
         end
         ATIVO: begin
            if (aceita) begin
               estado_d = OCIOSO;
            end else begin
               estado_d = ATIVO;
            end
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pedido_ant_q <= {N_CANAIS{1'b0}};
         pend_q       <= {N_CANAIS{1'b0}};
         estado_q     <= OCIOSO;
         saida_q      <= {LARGURA{1'b0}};
         causa_q      <= 4'd0;
         sobrep_q     <= 1'b0;
      end else begin
         pedido_ant_q <= pedido;
         pend_q       <= pend_d;
         estado_q     <= estado_d;
         saida_q      <= saida_d;
         causa_q      <= causa_d;
         sobrep_q     <= sobrep_d;
      end
   end

   assign saida        = saida_q;
   assign causa        = causa_q;
   assign pendente     = (estado_q == ATIVO);
   assign sobreposicao = sobrep_q;

endmodule
